// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter: state encoding and width defaults.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StOwn0 = 2'b01,
        StOwn1 = 2'b10
    } arb_state_e;

    localparam int unsigned AwDefault = 8;
    localparam int unsigned DwDefault = 8;
    localparam int unsigned HoldCntW  = 8;

endpackage

// File: rtl/arb_hold_ctr.sv
// Hold counter for the arbiter timeout: counts owner cycles and flags the last allowed one.
module arb_hold_ctr
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic terminal
);

    localparam logic [HoldCntW-1:0] TermVal = HoldCntW'(HOLD_MAX - 1);

    logic [HoldCntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != TermVal)) begin
            // Saturate so a long uncontested hold never wraps back below the terminal count.
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign terminal = (cnt_q == TermVal);

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester shared-memory arbiter with registered grants and a combinational memory mux.
// Optional owner timeout is built when ARB_TIMEOUT_EN is defined.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned AW       = AwDefault,
    parameter int unsigned DW       = DwDefault,
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic          busy
);

    arb_state_e state_q, state_d;
    logic       last_owner_q, last_owner_d;
    logic       timeout;

`ifdef ARB_TIMEOUT_EN
    logic entering;

    assign entering = (state_d != state_q) && (state_d != StIdle);

    arb_hold_ctr #(
        .HOLD_MAX (HOLD_MAX)
    ) u_hold_ctr (
        .clk      (clk),
        .rst      (rst),
        .clr      (entering),
        .inc      (state_q != StIdle),
        .terminal (timeout)
    );
`else
    logic unused_hold_max;

    assign unused_hold_max = ^8'(HOLD_MAX);
    assign timeout         = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        unique case (state_q)
            StIdle: begin
                if (req0 && req1) begin
                    state_d = last_owner_q ? StOwn0 : StOwn1;
                end else if (req0) begin
                    state_d = StOwn0;
                end else if (req1) begin
                    state_d = StOwn1;
                end
            end
            StOwn0: begin
                if (!req0 || (timeout && req1)) begin
                    state_d = req1 ? StOwn1 : StIdle;
                end
            end
            StOwn1: begin
                if (!req1 || (timeout && req0)) begin
                    state_d = req0 ? StOwn0 : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (state_d == StOwn0) begin
            last_owner_d = 1'b0;
        end else if (state_d == StOwn1) begin
            last_owner_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
        end
    end

    // Write strobe is gated by the live request so a dropped req kills it within the cycle.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        unique case (state_q)
            StOwn0: begin
                mem_addr  = addr0;
                mem_wdata = wdata0;
                mem_we    = we0 & req0;
            end
            StOwn1: begin
                mem_addr  = addr1;
                mem_wdata = wdata1;
                mem_we    = we1 & req1;
            end
            default: ;
        endcase
    end

    assign gnt0 = (state_q == StOwn0);
    assign gnt1 = (state_q == StOwn1);
    assign busy = gnt0 | gnt1;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (HOLD_MAX=4; timeout steps follow ARB_TIMEOUT_EN).
module tb_mem_arbiter;

    logic       clk, rst;
    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       gnt0, gnt1, mem_we, busy;
    logic [7:0] mem_addr, mem_wdata;

    int checks   = 0;
    int failures = 0;
    int held;

    mem_arbiter #(
        .AW       (8),
        .DW       (8),
        .HOLD_MAX (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        tick();
        tick();
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        rst = 1'b0;

        // Single read request: grant appears one edge later.
        req0 = 1; addr0 = 8'h12; we0 = 0;
        #1;
        chk("single_gnt0_pre", gnt0, 0);
        chk("single_addr_pre", mem_addr, 0);
        tick();
        chk("single_gnt0", gnt0, 1);
        chk("single_gnt1", gnt1, 0);
        chk("single_addr", mem_addr, 8'h12);
        chk("single_we", mem_we, 0);
        chk("single_busy", busy, 1);
        req0 = 0;
        tick();
        chk("single_release_gnt0", gnt0, 0);
        chk("single_release_addr", mem_addr, 0);

        // Fresh reset so the following tie starts from last_owner=1.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0 = 1; req1 = 1; addr0 = 8'h21; addr1 = 8'h40;
        tick();
        chk("tie1_gnt0", gnt0, 1);
        chk("tie1_gnt1", gnt1, 0);
        chk("tie1_addr", mem_addr, 8'h21);
        req0 = 0;
        tick();
        chk("handover_gnt0", gnt0, 0);
        chk("handover_gnt1", gnt1, 1);
        chk("handover_busy", busy, 1);

        we1 = 1; wdata1 = 8'hA5;
        #1;
        chk("wr_mem_we", mem_we, 1);
        chk("wr_mem_addr", mem_addr, 8'h40);
        chk("wr_mem_wdata", mem_wdata, 8'hA5);
        req1 = 0;
        #1;
        chk("wr_drop_mem_we", mem_we, 0);
        chk("wr_drop_gnt1_held", gnt1, 1);
        tick();
        chk("wr_drop_gnt1", gnt1, 0);
        chk("wr_drop_addr", mem_addr, 0);

        we1 = 0; req0 = 1; req1 = 1;
        tick();
        chk("tie2_gnt0", gnt0, 1);
        chk("tie2_gnt1", gnt1, 0);
        req0 = 0; req1 = 0;
        tick();
        chk("tie2_idle_busy", busy, 0);

        // Owner hold against a waiting requester.
        req0 = 1;
        tick();
        req1 = 1;
        held = 1;
        for (int i = 0; i < 24; i++) begin
            if (!gnt0) break;
            tick();
            if (gnt0) held++;
        end
`ifdef ARB_TIMEOUT_EN
        chk("timeout_hold_cycles", held, 4);
        chk("timeout_gnt1", gnt1, 1);
        chk("timeout_gnt0", gnt0, 0);
`else
        chk("nohold_cycles", held, 25);
        chk("nohold_gnt0", gnt0, 1);
        chk("nohold_gnt1", gnt1, 0);
`endif
        req0 = 0; req1 = 0;
        tick();
        chk("hold_release_busy", busy, 0);

        // Async reset in the middle of an OWN1 write.
        req1 = 1; we1 = 1; addr1 = 8'h40; wdata1 = 8'hA5;
        tick();
        chk("ar_gnt1", gnt1, 1);
        chk("ar_mem_we", mem_we, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_gnt1_drop", gnt1, 0);
        chk("ar_busy_drop", busy, 0);
        chk("ar_mem_we_drop", mem_we, 0);
        chk("ar_mem_addr_drop", mem_addr, 0);
        rst = 1'b0; req0 = 1; req1 = 1; we1 = 0;
        tick();
        chk("ar_tie_gnt0", gnt0, 1);
        chk("ar_tie_gnt1", gnt1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 8: address width.
REQ-002 Parameter DW, default 8: data width.
REQ-003 Parameter HOLD_MAX, default 8: maximum consecutive grant cycles while the other requester waits (ARB_TIMEOUT_EN only); legal range 2..255.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 req0/req1  input  1  access request from requester 0 (CPU controller) / requester 1 (loader/DMA).
REQ-007 we0/we1  input  1  write enable of requester n; 1=write, 0=read.
REQ-008 addr0/addr1  input  AW  address of requester n.
REQ-009 wdata0/wdata1  input  DW  write data of requester n.
REQ-010 gnt0/gnt1  output  1  registered grant to requester n.
REQ-011 mem_addr  output  AW  shared memory address.
REQ-012 mem_wdata  output  DW  shared memory write data.
REQ-013 mem_we  output  1  shared memory write strobe (MemRW equivalent).
REQ-014 busy  output  1  high whenever either grant is high.

Function
REQ-015 FSM states: IDLE, OWN0, OWN1; gntn=1 only in OWNn; gnt0 and gnt1 are never both high.
REQ-016 IDLE: exactly one req high -> OWN of that requester next edge; both high -> requester not equal to last_owner; none -> stay IDLE.
REQ-017 Grant latency: gnt rises exactly one cycle after the edge sampling req high in IDLE.
REQ-018 OWNn with reqn=1 and no timeout: stay OWNn.
REQ-019 OWNn with reqn=0: go to OWN(other) if other req high, else IDLE; no idle bubble on handover.
REQ-020 last_owner register updates to n on every entry into OWNn.
REQ-021 Memory mux: in OWNn, mem_addr=addrn, mem_wdata=wdatan, mem_we=wen (combinational from inputs); in IDLE all three are 0.
REQ-022 mem_we SHALL never be high while both grants are low.
REQ-023 Requester drops req mid-write: mem_we falls combinationally in the same cycle; grant drops next edge.

Reset
REQ-024 On rst: state=IDLE, gnt0=gnt1=0, busy=0, mem_we=0, mem_addr=0, mem_wdata=0, last_owner=1 (requester 0 wins first tie), hold counter=0.
REQ-025 rst asserted mid-grant removes the grant immediately (asynchronously); after release the arbiter re-arbitrates from IDLE.

Configuration
REQ-026 Macro ARB_TIMEOUT_EN defined: hold counter clears on entry to OWNn and increments each OWNn cycle; at count HOLD_MAX-1 with the other req high, the next edge forces OWN(other); the preempted requester keeps req high and is regranted by normal rules.
REQ-027 ARB_TIMEOUT_EN undefined: no counter is built; the owner holds until it drops req; HOLD_MAX is ignored.

Structure
REQ-028 Shared package holds the state encoding (IDLE=2'b00, OWN0=2'b01, OWN1=2'b10) and the AW/DW defaults.
REQ-029 One sub-module, arb_hold_ctr (hold counter with terminal flag), instantiated only under ARB_TIMEOUT_EN; the mux stays in mem_arbiter.

Verification
REQ-030 Single request: req0=1, addr0=8'h12, we0=0 at cycle 0 -> gnt0=1 at cycle 1, mem_addr=8'h12, mem_we=0, gnt1=0.
REQ-031 Tie after reset: req0=req1=1 -> gnt0 first; req0 drops -> gnt1 on the next edge with no IDLE cycle; next tie -> gnt0.
REQ-032 Write path: OWN1, we1=1, addr1=8'h40, wdata1=8'hA5 -> mem_we=1, mem_addr=8'h40, mem_wdata=8'hA5; req1 low -> mem_we=0 same cycle.
REQ-033 Timeout (ARB_TIMEOUT_EN, HOLD_MAX=4): req0 held, req1 asserted -> gnt0 high exactly 4 cycles, then gnt1; with macro off, gnt0 held 20+ cycles.
REQ-034 Async reset during OWN1 write: rst pulse mid-cycle -> gnt1, busy, mem_we drop before the next edge; after release with req0=req1=1 -> gnt0 first.
